// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite register bridge.
package axil_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam int unsigned TMR_W       = 8;

    typedef enum logic [1:0] {
        W_COLLECT = 2'd0,
        W_ISSUE   = 2'd1,
        W_RESP    = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axil_rd_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module axil_rd_timer
    import axil_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             expired_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == '0);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave bridging single outstanding reads/writes onto a strobed register bus.
module axil_reg_bridge
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_SPAN  = 4096,
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [DATA_W-1:0]     S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [DATA_W-1:0]     S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic                  reg_wr,
    output logic [ADDR_W-1:0]     reg_waddr,
    output logic [DATA_W-1:0]     reg_wdata,
    output logic [DATA_W/8-1:0]   reg_wstrb,
    output logic                  reg_rd,
    output logic [ADDR_W-1:0]     reg_raddr,
    input  logic [DATA_W-1:0]     reg_rdata,
    input  logic                  reg_rvalid
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB_W  = $clog2(STRB_W);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 33'(a) < 33'(ADDR_SPAN);
    endfunction

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r            = a;
        r[LSB_W-1:0] = '0;
        return r;
    endfunction

    // ---------------- write path ----------------
    wr_state_e          wst_q, wst_d;
    logic               aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic               awready_q, awready_d, wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic               reg_wr_q, reg_wr_d;
    logic [ADDR_W-1:0]  reg_waddr_q, reg_waddr_d;
    logic [DATA_W-1:0]  reg_wdata_q, reg_wdata_d;
    logic [STRB_W-1:0]  reg_wstrb_q, reg_wstrb_d;

    always_comb begin
        wst_d       = wst_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awready_d   = 1'b0;
        wready_d    = 1'b0;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        reg_wr_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wstrb_d = reg_wstrb_q;
        unique case (wst_q)
            W_COLLECT: begin
                if (S_AXI_AWVALID && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = S_AXI_AWADDR;
                end
                if (S_AXI_WVALID && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                end
                // Both halves present: launch the register write on the next cycle.
                if (aw_held_d && w_held_d) begin
                    wst_d       = W_ISSUE;
                    reg_wr_d    = in_range(awaddr_d);
                    reg_waddr_d = align(awaddr_d);
                    reg_wdata_d = wdata_d;
                    reg_wstrb_d = wstrb_d;
                    bresp_d     = in_range(awaddr_d) ? RESP_OKAY : RESP_SLVERR;
                end else begin
                    awready_d = ~aw_held_d;
                    wready_d  = ~w_held_d;
                end
            end
            W_ISSUE: begin
                wst_d    = W_RESP;
                bvalid_d = 1'b1;
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wst_d     = W_COLLECT;
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: wst_d = W_COLLECT;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            wst_q       <= W_COLLECT;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            reg_wr_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
            reg_wstrb_q <= '0;
        end else begin
            wst_q       <= wst_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            reg_wr_q    <= reg_wr_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wstrb_q <= reg_wstrb_d;
        end
    end

    // ---------------- read path ----------------
    rd_state_e          rst_q, rst_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               reg_rd_q, reg_rd_d;
    logic [ADDR_W-1:0]  reg_raddr_q, reg_raddr_d;
    logic               tmr_load, tmr_en, tmr_expired;

    always_comb begin
        rst_d       = rst_q;
        arready_d   = 1'b0;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        reg_rd_d    = 1'b0;
        reg_raddr_d = reg_raddr_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        unique case (rst_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && arready_q) begin
                    if (in_range(S_AXI_ARADDR)) begin
                        rst_d       = R_WAIT;
                        reg_rd_d    = 1'b1;
                        reg_raddr_d = align(S_AXI_ARADDR);
                        tmr_load    = 1'b1;
                    end else begin
                        rst_d    = R_RESP;
                        rvalid_d = 1'b1;
                        rdata_d  = '0;
                        rresp_d  = RESP_SLVERR;
                    end
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_WAIT: begin
                tmr_en = 1'b1;
                // Data arriving on the last counted cycle still wins over the timeout.
                if (reg_rvalid) begin
                    rst_d    = R_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = reg_rdata;
                    rresp_d  = RESP_OKAY;
                end else if (tmr_expired) begin
                    rst_d    = R_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                end
            end
            R_RESP: begin
                if (S_AXI_RREADY) begin
                    rst_d     = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: rst_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rst_q       <= R_IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rresp_q     <= 2'b00;
            rdata_q     <= '0;
            reg_rd_q    <= 1'b0;
            reg_raddr_q <= '0;
        end else begin
            rst_q       <= rst_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            reg_rd_q    <= reg_rd_d;
            reg_raddr_q <= reg_raddr_d;
        end
    end

    axil_rd_timer u_rd_timer (
        .clk_i      (S_AXI_ACLK),
        .rst_i      (S_AXI_ARESET),
        .load_i     (tmr_load),
        .load_val_i (TMR_W'(RD_TIMEOUT - 1)),
        .en_i       (tmr_en),
        .expired_o  (tmr_expired)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_wr        = reg_wr_q;
    assign reg_waddr     = reg_waddr_q;
    assign reg_wdata     = reg_wdata_q;
    assign reg_wstrb     = reg_wstrb_q;
    assign reg_rd        = reg_rd_q;
    assign reg_raddr     = reg_raddr_q;

endmodule

// File: doc/axil_reg_bridge.md
Name: axil_reg_bridge

Overview:
Parametrised AXI4-Lite slave that bridges PS register accesses onto a simple internal register bus. It is the successor to the fixed 16/32-bit register interface. It adds:
- independent AW/W arrival
- byte strobes
- variable-latency reads with timeout
- SLVERR for out-of-range addresses
It sits between the PS GP port interconnect and the DMA control/status register file.

Parameters:
ADDR_W, 16, AXI and register-bus address width in bits.
DATA_W, 32, data width in bits; 32 or 64 only.
ADDR_SPAN, 4096, number of decoded bytes; addresses >= ADDR_SPAN get SLVERR.
RD_TIMEOUT, 16, cycles to wait for reg_rvalid after reg_rd; range 1..255.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  asynchronous active-high reset
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWVALID  in  1  AW valid
S_AXI_AWREADY  out  1  AW ready
S_AXI_WDATA  in  DATA_W  write data
S_AXI_WSTRB  in  DATA_W/8  byte strobes
S_AXI_WVALID  in  1  W valid
S_AXI_WREADY  out  1  W ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  B valid
S_AXI_BREADY  in  1  B ready
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARVALID  in  1  AR valid
S_AXI_ARREADY  out  1  AR ready
S_AXI_RDATA  out  DATA_W  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  R valid
S_AXI_RREADY  in  1  R ready
reg_wr  out  1  one-cycle write strobe
reg_waddr  out  ADDR_W  write address, low log2(DATA_W/8) bits forced 0
reg_wdata  out  DATA_W  write data
reg_wstrb  out  DATA_W/8  byte enables
reg_rd  out  1  one-cycle read strobe
reg_raddr  out  ADDR_W  read address, low bits forced 0
reg_rdata  in  DATA_W  read data
reg_rvalid  in  1  read data valid; may be asserted in the reg_rd cycle or later

Behaviour:
- Reset (async assert, sync release): every output is 0, both FSMs go to IDLE, any in-flight transaction is dropped with no response. AWPROT/ARPROT are not present.
- Write FSM, states W_COLLECT, W_ISSUE, W_RESP:
  - W_COLLECT: AWREADY=1 while no address is held; WREADY=1 while no data is held. AW and W are captured independently, in either order or the same cycle.
  - When both are held, go to W_ISSUE.
  - W_ISSUE lasts one cycle. reg_wr=1 only if the address is < ADDR_SPAN; reg_waddr, reg_wdata and reg_wstrb are registered and stable from this cycle until the next W_ISSUE. Then go to W_RESP.
  - W_RESP: BVALID=1, BRESP=00 (OKAY) or 10 (SLVERR, out-of-range). Hold until BREADY, then return to W_COLLECT with both holders empty.
  - Latency: AW+W in cycle 0 -> reg_wr in cycle 1 -> BVALID in cycle 2.
  - AWREADY and WREADY are 0 outside W_COLLECT.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: ARREADY=1. On the AR handshake, latch the address.
    - In range: pulse reg_rd the next cycle and enter R_WAIT.
    - Out of range: go straight to R_RESP with SLVERR and RDATA=0; reg_rd is never pulsed.
  - R_WAIT: a timeout counter starts at 0 in the reg_rd cycle.
    - If reg_rvalid is seen (including the reg_rd cycle itself), capture reg_rdata and set RESP=OKAY.
    - If the counter reaches RD_TIMEOUT-1 with no reg_rvalid, set RDATA=0 and RESP=SLVERR.
    - Either way, enter R_RESP.
  - R_RESP: RVALID=1; RDATA and RRESP are held stable until RREADY, then return to R_IDLE.
  - ARREADY is 0 outside R_IDLE.
  - A reg_rvalid outside R_WAIT is ignored.
  - Minimum latency: AR in cycle 0 -> reg_rd in cycle 1 -> RVALID in cycle 2 (when reg_rvalid coincides with reg_rd).
- Read and write paths are fully independent; reg_wr and reg_rd may assert in the same cycle.
- Range check is an unsigned compare of the full address against ADDR_SPAN.
- Backpressure: BVALID/RVALID never drop without a handshake. There is no outstanding depth beyond one transaction per direction.

Decomposition:
- Shared package axil_pkg holds:
  - response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - write-FSM state typedef
  - read-FSM state typedef
- One natural sub-module: axil_rd_timer, a loadable down-counter with an expiry flag, instanced in the read path.

Test Plan:
- AW and W same cycle, addr 0x0010, data 0xA5A5_0001, strb 0xF -> reg_wr high exactly in cycle 1 with reg_waddr 0x0010, reg_wstrb 0xF; BVALID in cycle 2 with BRESP 00.
- W two cycles before AW (addr 0x0020, strb 0x3) -> one reg_wr only after AW; reg_wstrb 0x3; BRESP 00.
- Write to 0x1000 (ADDR_SPAN=4096) -> no reg_wr; BRESP 10. Read from 0x1004 -> no reg_rd; RRESP 10, RDATA 0.
- Read 0x0008, reg_rvalid 3 cycles after reg_rd with data 0x1234_5678 -> RVALID one cycle later with that data and RRESP 00; RREADY held low 5 cycles -> RDATA stable throughout.
- Read with reg_rvalid never asserted, RD_TIMEOUT=16 -> RVALID exactly 16 cycles after reg_rd with RRESP 10, RDATA 0.
- Assert S_AXI_ARESET while BVALID=1 and R_WAIT is active -> all outputs 0 asynchronously; after release, a fresh write completes normally.
